// File: rtl/eth_axis_pkg.sv
// Shared definitions for the 64-bit Ethernet AXI-Stream TX path:
// beat field widths and the arbiter FSM state encoding.
package eth_axis_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int USER_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin priority encoder: returns a one-hot grant for
// the first asserted request found scanning upward from ptr, modulo P_NUM.
module axis_rr_pick #(
  parameter int P_NUM   = 2,
  parameter int P_PTR_W = 1
) (
  input  logic [P_NUM-1:0]   req,
  input  logic [P_PTR_W-1:0] ptr,
  output logic [P_NUM-1:0]   gnt
);

  logic               found_s;
  logic [P_PTR_W-1:0] idx_s;

  // scan requests starting at the priority pointer, first hit wins
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int off = 0; off < P_NUM; off++) begin
      idx_s = P_PTR_W'((int'(ptr) + off) % P_NUM);
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: merges P_NUM_SRC AXI-Stream sources onto
// one 64-bit stream. A grant is held from first beat to the accepted tlast
// beat, so packets never interleave; one idle cycle separates packets.
// Optional feature macro: ARB_PKT_CNT_EN builds per-source packet counters;
// without it o_pkt_cnt is tied to zero.
module axis_pkt_rr_arbiter
  import eth_axis_pkg::*;
#(
  parameter int P_NUM_SRC = 2,
  parameter int P_CNT_W   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_W*P_NUM_SRC-1:0]   s_axis_tdata,
  input  logic [USER_W*P_NUM_SRC-1:0]   s_axis_tuser,
  input  logic [KEEP_W*P_NUM_SRC-1:0]   s_axis_tkeep,
  input  logic [P_NUM_SRC-1:0]          s_axis_tlast,
  input  logic [P_NUM_SRC-1:0]          s_axis_tvalid,
  output logic [P_NUM_SRC-1:0]          m_axis_tready,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic [USER_W-1:0]             m_axis_tuser,
  output logic [KEEP_W-1:0]             m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          s_axis_tready,
  output logic [P_NUM_SRC-1:0]          o_grant,
  output logic [P_CNT_W*P_NUM_SRC-1:0]  o_pkt_cnt
);

  localparam int PTR_W = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1;

  // index of the (single) set bit of a one-hot vector
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [P_NUM_SRC-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < P_NUM_SRC; i++) begin
      if (oh[i]) begin
        idx = PTR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  arb_state_t             state_r, state_s;
  logic [P_NUM_SRC-1:0]   grant_r, grant_s;
  logic [PTR_W-1:0]       gidx_r, gidx_s;
  logic [PTR_W-1:0]       ptr_r, ptr_s;
  logic [P_NUM_SRC-1:0]   pick_gnt_s;
  logic                   last_acc_s;

  axis_rr_pick #(
    .P_NUM   (P_NUM_SRC),
    .P_PTR_W (PTR_W)
  ) u_pick (
    .req (s_axis_tvalid),
    .ptr (ptr_r),
    .gnt (pick_gnt_s)
  );

  assign o_grant    = grant_r;
  assign last_acc_s = m_axis_tvalid & s_axis_tready & m_axis_tlast;

  // FSM state, grant and priority pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      gidx_r  <= gidx_s;
      ptr_r   <= ptr_s;
    end
  end

  // next-state: arbitrate in IDLE, hold grant in BUSY until tlast is accepted
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    gidx_s  = gidx_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          state_s = ST_BUSY;
          grant_s = pick_gnt_s;
          gidx_s  = onehot_to_idx(pick_gnt_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_acc_s) begin
          state_s = ST_IDLE;
          grant_s = '0;
          if (gidx_r == PTR_W'(P_NUM_SRC - 1)) begin
            ptr_s = '0;
          end else begin
            ptr_s = gidx_r + PTR_W'(1);
          end
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = '0;
        gidx_s  = '0;
        ptr_s   = '0;
      end
    endcase
  end

  // output mux: granted source passes straight through, everything zero when idle
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tkeep  = '0;
    m_axis_tready = '0;
    if (state_r == ST_BUSY) begin
      m_axis_tvalid         = s_axis_tvalid[gidx_r];
      m_axis_tlast          = s_axis_tlast[gidx_r];
      m_axis_tdata          = s_axis_tdata[gidx_r*DATA_W +: DATA_W];
      m_axis_tuser          = s_axis_tuser[gidx_r*USER_W +: USER_W];
      m_axis_tkeep          = s_axis_tkeep[gidx_r*KEEP_W +: KEEP_W];
      m_axis_tready[gidx_r] = s_axis_tready;
    end else begin
      m_axis_tvalid = 1'b0;
      m_axis_tready = '0;
    end
  end

`ifdef ARB_PKT_CNT_EN
  logic [P_CNT_W*P_NUM_SRC-1:0] pkt_cnt_r;

  // count accepted end-of-packet beats per source, wrapping naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_r <= '0;
    end else if (last_acc_s) begin
      pkt_cnt_r[gidx_r*P_CNT_W +: P_CNT_W] <= pkt_cnt_r[gidx_r*P_CNT_W +: P_CNT_W] + P_CNT_W'(1);
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign o_pkt_cnt = pkt_cnt_r;
`else
  assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench for axis_pkt_rr_arbiter (N=2, 4-bit packet counters).
// Per-source drivers push every issued beat into a per-source scoreboard queue;
// a negedge monitor runs a packet-level round-robin reference model and pops
// and compares whenever the merged stream transfers a beat.
module tb_axis_pkt_rr_arbiter;

  localparam int N  = 2;
  localparam int CW = 4;

  typedef struct {
    int          len;
    logic [31:0] user;
    logic [7:0]  last_keep;
    int          bubble;
    bit          rnd_gap;
  } job_t;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [64*N-1:0] s_axis_tdata;
  logic [32*N-1:0] s_axis_tuser;
  logic [8*N-1:0]  s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    m_axis_tready;
  logic [63:0]     m_axis_tdata;
  logic [31:0]     m_axis_tuser;
  logic [7:0]      m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            ds_ready;
  logic [N-1:0]    o_grant;
  logic [CW*N-1:0] o_pkt_cnt;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;

  job_t  job_q [N][$];
  beat_t exp_q [N][$];
  int    pushed [N];
  int    dut_order[$];

  // reference model state
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int cnt_model [N];

  axis_pkt_rr_arbiter #(.P_NUM_SRC(N), .P_CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .s_axis_tready (ds_ready),
    .o_grant       (o_grant),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_job(input int k, input int len, input logic [31:0] user,
                          input logic [7:0] last_keep, input int bubble, input bit rnd_gap);
    job_t j;
    j.len = len; j.user = user; j.last_keep = last_keep; j.bubble = bubble; j.rnd_gap = rnd_gap;
    job_q[k].push_back(j);
    pushed[k]++;
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < N; k++) begin
      if (job_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
    end
    return !m_busy && (s_axis_tvalid == '0);
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && !all_idle()) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) begin
      errors++; checks++;
      $display("FAIL drain_timeout actual=%0d cycles required<%0d", c, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  // source drivers
  for (genvar gk = 0; gk < N; gk++) begin : g_src
    logic [63:0] d;
    logic [31:0] u;
    logic [7:0]  kp;
    logic        l;
    logic        v;
    assign s_axis_tdata[64*gk +: 64] = d;
    assign s_axis_tuser[32*gk +: 32] = u;
    assign s_axis_tkeep[8*gk +: 8]   = kp;
    assign s_axis_tlast[gk]          = l;
    assign s_axis_tvalid[gk]         = v;

    initial begin
      job_t  j;
      beat_t b;
      bit    acc;
      int    wc;
      d = '0; u = '0; kp = '0; l = 1'b0; v = 1'b0;
      @(posedge rst_n);
      @(posedge clk); #1;
      forever begin
        while (job_q[gk].size() == 0) begin
          v = 1'b0;
          @(posedge clk); #1;
        end
        j = job_q[gk].pop_front();
        for (int bi = 0; bi < j.len; bi++) begin
          if (j.bubble > 0 && bi == 2) begin
            v = 1'b0;
            repeat (j.bubble) begin @(posedge clk); #1; end
          end else if (j.rnd_gap && $urandom_range(3) == 0) begin
            v = 1'b0;
            @(posedge clk); #1;
          end
          b.data = {$urandom, $urandom};
          b.user = j.user;
          b.keep = (bi == j.len - 1) ? j.last_keep : 8'hFF;
          b.last = (bi == j.len - 1);
          exp_q[gk].push_back(b);
          d = b.data; u = b.user; kp = b.keep; l = b.last; v = 1'b1;
          acc = 1'b0;
          wc = 0;
          while (!acc) begin
            @(negedge clk);
            acc = m_axis_tready[gk] && v;
            @(posedge clk); #1;
            wc++;
            if (!acc && wc > 2000) begin
              errors++; checks++;
              $display("FAIL src%0d_accept_timeout actual=%0d cycles required<2000", gk, wc);
              acc = 1'b1;
            end
          end
        end
      end
    end
  end

  // downstream ready pattern
  initial begin
    ds_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ds_ready = 1'b1;
        1:       ds_ready = ~ds_ready;
        default: ds_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // monitor: packet-level reference model plus scoreboard comparison
  initial begin
    logic [N-1:0] eg, er, prev_g;
    beat_t b;
    int idx;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs",
              {m_axis_tvalid, m_axis_tlast, m_axis_tready, o_grant, o_pkt_cnt,
               m_axis_tdata, m_axis_tuser, m_axis_tkeep}, '0);
        m_busy = 1'b0; m_owner = 0; m_ptr = 0;
        for (int k = 0; k < N; k++) cnt_model[k] = 0;
        prev_g = '0;
      end else begin
        if (prev_g == '0 && o_grant != '0) begin
          for (int k = 0; k < N; k++) if (o_grant[k]) dut_order.push_back(k);
        end
        prev_g = o_grant;
        eg = '0; er = '0;
        if (m_busy) begin eg[m_owner] = 1'b1; er[m_owner] = ds_ready; end
        check("grant", o_grant, eg);
        check("src_tready", m_axis_tready, er);
        check("m_tvalid", m_axis_tvalid, m_busy ? s_axis_tvalid[m_owner] : 1'b0);
`ifdef ARB_PKT_CNT_EN
        for (int k = 0; k < N; k++) check("pkt_cnt", o_pkt_cnt[k*CW +: CW], cnt_model[k] % (1 << CW));
`else
        check("pkt_cnt_tied", o_pkt_cnt, '0);
`endif
        if (!m_busy) begin
          check("idle_outputs_zero", {m_axis_tlast, m_axis_tdata, m_axis_tuser, m_axis_tkeep}, '0);
          for (int i = 0; i < N; i++) begin
            idx = (m_ptr + i) % N;
            if (s_axis_tvalid[idx]) begin
              m_busy = 1'b1;
              m_owner = idx;
              break;
            end
          end
        end else if (s_axis_tvalid[m_owner] && ds_ready) begin
          if (exp_q[m_owner].size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_beat src=%0d actual=%h required=none", m_owner, m_axis_tdata);
          end else begin
            b = exp_q[m_owner].pop_front();
            check("beat", {m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast}, b);
            if (b.last) begin
              cnt_model[m_owner]++;
              m_busy = 1'b0;
              m_ptr = (m_owner + 1) % N;
            end
          end
        end
      end
    end
  end

  // global time limit
  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout actual=%0t required=done", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "global timeout");
  end

  // directed and random test sequence
  initial begin
    int exp_ord [4];
    for (int k = 0; k < N; k++) pushed[k] = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 16-beat packet from src0 with tuser 0x80
    @(negedge clk);
    push_job(0, 16, 32'h80, 8'hFF, 0, 1'b0);
    drain(400);
    check("t1_grant_count", dut_order.size(), 1);
    if (dut_order.size() > 0) check("t1_grant_src", dut_order[0], 0);

    // back-to-back single-beat packets from src1 only
    dut_order.delete();
    for (int i = 0; i < 4; i++) push_job(1, 1, 32'h1, 8'h0F, 0, 1'b0);
    drain(200);
    check("t5_grant_count", dut_order.size(), 4);
    foreach (dut_order[i]) check("t5_grant_src", dut_order[i], 1);

    // both sources continuously valid with 4-beat packets
    dut_order.delete();
    exp_ord = '{0, 1, 0, 1};
    for (int i = 0; i < 2; i++) begin
      push_job(0, 4, 32'h20, 8'hFF, 0, 1'b0);
      push_job(1, 4, 32'h21, 8'h3F, 0, 1'b0);
    end
    drain(300);
    check("t2_grant_count", dut_order.size(), 4);
    for (int i = 0; i < 4 && i < dut_order.size(); i++) check("t2_grant_order", dut_order[i], exp_ord[i]);

    // src1 requests while src0 packet is in flight
    dut_order.delete();
    push_job(0, 8, 32'h30, 8'hFF, 0, 1'b0);
    repeat (3) @(negedge clk);
    push_job(1, 3, 32'h31, 8'h01, 0, 1'b0);
    drain(300);
    check("t3_grant_count", dut_order.size(), 2);
    if (dut_order.size() == 2) begin
      check("t3_first", dut_order[0], 0);
      check("t3_second", dut_order[1], 1);
    end

    // downstream ready toggling plus a 3-cycle source bubble, tkeep F0 last beat
    rdy_mode = 1;
    push_job(0, 8, 32'h40, 8'hF0, 3, 1'b0);
    drain(300);
    rdy_mode = 0;

    // randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 24; i++) begin
      push_job($urandom_range(N - 1), $urandom_range(6, 1), $urandom, 8'($urandom_range(255, 1)),
               0, 1'b1);
      repeat ($urandom_range(4)) @(negedge clk);
    end
    drain(4000);
    rdy_mode = 0;

    // 17 packets from src0 exercise the counter wrap
    for (int i = 0; i < 17; i++) push_job(0, 1, 32'h60, 8'hFF, 0, 1'b0);
    drain(400);
`ifdef ARB_PKT_CNT_EN
    check("t6_cnt_src0", o_pkt_cnt[0 +: CW], pushed[0] % (1 << CW));
    check("t6_cnt_src1", o_pkt_cnt[CW +: CW], pushed[1] % (1 << CW));
`else
    check("t6_cnt_tied", o_pkt_cnt, '0);
`endif

    // asynchronous reset in the middle of a packet
    push_job(0, 20, 32'h70, 8'hFF, 0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    check("t6_busy_before_reset", o_grant, 2'b01);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset",
          {m_axis_tvalid, m_axis_tlast, m_axis_tready, o_grant, o_pkt_cnt,
           m_axis_tdata, m_axis_tuser, m_axis_tkeep}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
